// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch, decode and
// per-class execute steps, decoding datapath controls from the state register.
module mc_control_fsm #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_J     = 6'h02
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Op,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       PCSource,
  output logic       Jump,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RCOMP  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9
  } state_t;

  state_t state_q, state_d;

  // Next-state selection; Op is consulted only in DECODE and MEMADR.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        if (Op == OP_LW || Op == OP_SW) state_d = MEMADR;
        else if (Op == OP_RTYPE)        state_d = EXEC;
        else if (Op == OP_BEQ)          state_d = BRANCH;
        else if (Op == OP_J)            state_d = JUMP;
        else                            state_d = FETCH;
      end
      MEMADR: state_d = (Op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  state_d = MEMWB;
      MEMWB:  state_d = FETCH;
      MEMWR:  state_d = FETCH;
      EXEC:   state_d = RCOMP;
      RCOMP:  state_d = FETCH;
      BRANCH: state_d = FETCH;
      JUMP:   state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // State register; reset returns to FETCH immediately.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Moore output decode from the state register alone. Kept as a decode of
  // state_q rather than a separate output register so that stray encodings
  // 10-15 show all-zero controls in the same cycle they appear.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = '0;
    ALUOp       = '0;
    PCSource    = 1'b0;
    Jump        = 1'b0;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = 1'b1;
      end
      DECODE: ALUSrcB = 2'b11;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      RCOMP: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
      end
      JUMP: begin
        PCWrite = 1'b1;
        Jump    = 1'b1;
      end
      default: ;
    endcase
  end

  assign State = state_q;

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameter OP_RTYPE, default 6'h00, R-type opcode.
REQ-002 Parameter OP_LW, default 6'h23, load-word opcode.
REQ-003 Parameter OP_SW, default 6'h2B, store-word opcode.
REQ-004 Parameter OP_BEQ, default 6'h04, branch-equal opcode.
REQ-005 Parameter OP_J, default 6'h02, jump opcode.
REQ-006 Clk  input  1  single clock; all state changes on rising edge.
REQ-007 Reset  input  1  asynchronous, active-high; forces state FETCH immediately.
REQ-008 Op  input  6  opcode field of the instruction register.
REQ-009 PCWrite  output  1  unconditional PC load enable.
REQ-010 PCWriteCond  output  1  PC load enable qualified by ALU Zero (beq).
REQ-011 IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-012 MemRead / MemWrite  output  1 each  memory strobes.
REQ-013 IRWrite  output  1  instruction register load enable.
REQ-014 MemtoReg  output  1  register write data select: 1 = MDR.
REQ-015 RegDst  output  1  destination select: 1 = rd, 0 = rt.
REQ-016 RegWrite  output  1  register file write enable.
REQ-017 ALUSrcA  output  1  0 = PC, 1 = register A.
REQ-018 ALUSrcB  output  2  00 = B, 01 = constant 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
REQ-019 ALUOp  output  2  00 = add, 01 = subtract, 10 = funct-decoded.
REQ-020 PCSource  output  1  0 = ALU result, 1 = ALUOut (branch target).
REQ-021 Jump  output  1  select for the downstream 32-bit jump mux: 1 = jump target, 0 = PCSource path.
REQ-022 State  output  4  current state encoding, for debug.

Function
REQ-023 Moore machine: all outputs SHALL decode from the registered state only; Op SHALL affect the next state only.
REQ-024 States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RCOMP=7, BRANCH=8, JUMP=9; encodings 10-15 unreachable, SHALL go to FETCH next cycle with all outputs 0.
REQ-025 Every output not listed for a state SHALL be 0 in that state.
REQ-026 FETCH: MemRead=1, IRWrite=1, ALUSrcB=01, PCWrite=1; next DECODE.
REQ-027 DECODE: ALUSrcB=11; next per Op: LW/SW->MEMADR, RTYPE->EXEC, BEQ->BRANCH, J->JUMP, any other->FETCH.
REQ-028 MEMADR: ALUSrcA=1, ALUSrcB=10; next MEMRD if Op==OP_LW, else MEMWR.
REQ-029 MEMRD: MemRead=1, IorD=1; next MEMWB.
REQ-030 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; next FETCH.
REQ-031 MEMWR: MemWrite=1, IorD=1; next FETCH.
REQ-032 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next RCOMP.
REQ-033 RCOMP: RegWrite=1, RegDst=1, MemtoReg=0; next FETCH.
REQ-034 BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=1; next FETCH.
REQ-035 JUMP: PCWrite=1, Jump=1; next FETCH.
REQ-036 Latency in cycles from FETCH to next FETCH: R-type 4, lw 5, sw 4, beq 3, j 3, illegal 2.
REQ-037 Jump SHALL be 1 only in JUMP; PCWrite and PCWriteCond SHALL never both be 1.
REQ-038 Op changing outside DECODE/MEMADR SHALL have no effect.

Reset
REQ-039 While Reset=1: State=0 (FETCH), outputs hold FETCH values; PC/IR reset in the datapath has priority over PCWrite/IRWrite.
REQ-040 Reset asserted mid-instruction SHALL abandon it with no further MemWrite/RegWrite; first rising edge after release moves FETCH->DECODE.

Verification
REQ-041 Reset high 3 cycles, release -> State=0, MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01; next edge State=1.
REQ-042 Op=6'h00 -> State 0,1,6,7,0; RegWrite=1, RegDst=1 only in 7; ALUOp=10 only in 6.
REQ-043 Op=6'h23 -> 0,1,2,3,4,0; IorD=1 in 3; MemtoReg=1, RegWrite=1 in 4. Op=6'h2B -> 0,1,2,5,0; MemWrite=1 only in 5.
REQ-044 Op=6'h04 -> 0,1,8,0 with PCWriteCond=1, ALUOp=01, PCSource=1 in 8; Op=6'h02 -> 0,1,9,0 with Jump=1, PCWrite=1 in 9 and Jump=0 elsewhere.
REQ-045 Op=6'h3F -> 0,1,0, no write strobe asserted in the sequence.
REQ-046 Reset pulsed asynchronously while State=3 (lw) -> State=0 before next edge; MEMWB never entered; normal fetch resumes.
